// File: rtl/baggage_drop_pkg.sv
// Shared types and widths for the baggage-drop sequencing controller.
package baggage_drop_pkg;

    localparam int unsigned T_W   = 16;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StArmed    = 3'd1,
        StConfirm  = 3'd2,
        StRelease  = 3'd3,
        StCooldown = 3'd4
    } state_e;

endpackage

// File: rtl/cycle_timer.sv
// Loadable up/down cycle counter with a zero flag, shared across controller phases.
module cycle_timer
    import baggage_drop_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic [T_W-1:0] load_val,
    input  logic           en,
    input  logic           up,
    output logic [T_W-1:0] cnt,
    output logic           zero
);

    logic [T_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en) begin
            cnt_q <= up ? cnt_q + 1'b1 : cnt_q - 1'b1;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/baggage_drop_ctrl.sv
// Baggage-drop sequencer: arm, confirm release condition, pulse hook, cool down.
module baggage_drop_ctrl
    import baggage_drop_pkg::*;
#(
    parameter int unsigned CONFIRM_N       = 3,
    parameter int unsigned RELEASE_CYCLES  = 4,
    parameter int unsigned COOLDOWN_CYCLES = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm_req,
    input  logic             abort,
    input  logic [T_W-1:0]   t_act,
    input  logic             t_act_valid,
    input  logic [T_W-1:0]   t_lim,
    output logic             drop_en,
    output logic             release_o,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             timeout_o,
    output logic [2:0]       state_o
);

    state_e           state_q, state_d;
    logic [3:0]       conf_q, conf_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             timeout_q, timeout_d;

    logic             tmr_load, tmr_en, tmr_up, tmr_zero;
    logic [T_W-1:0]   tmr_val, tmr_cnt;
    logic             ok, bad;
    logic [3:0]       conf_inc;

    assign ok       = t_act_valid && (t_act <= t_lim);
    assign bad      = t_act_valid && !(t_act <= t_lim);
    assign conf_inc = conf_q + 4'd1;

    cycle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .up       (tmr_up),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d    = state_q;
        conf_d     = conf_q;
        drop_cnt_d = drop_cnt_q;
        timeout_d  = timeout_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        tmr_en     = 1'b0;
        tmr_up     = 1'b0;

        case (state_q)
            StIdle: begin
                if (arm_req && !abort) begin
                    state_d   = StArmed;
                    timeout_d = 1'b0;
                    conf_d    = '0;
                    tmr_load  = 1'b1;
                end
            end
            // Timer counts up through ARMED/CONFIRM; conf is 0 whenever in ARMED.
            StArmed, StConfirm: begin
                tmr_en = 1'b1;
                tmr_up = 1'b1;
                if (abort) begin
                    state_d = StIdle;
                end else if (ok && conf_inc == 4'(CONFIRM_N)) begin
                    state_d  = StRelease;
                    conf_d   = '0;
                    tmr_load = 1'b1;
                    tmr_val  = T_W'(RELEASE_CYCLES - 1);
                end else if (ok) begin
                    state_d = StConfirm;
                    conf_d  = conf_inc;
                end else if (bad && state_q == StConfirm) begin
                    state_d = StArmed;
                    conf_d  = '0;
                end else if (tmr_cnt >= T_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end
            end
            StRelease: begin
                if (tmr_zero) begin
                    state_d    = StCooldown;
                    drop_cnt_d = drop_cnt_q + 1'b1;
                    tmr_load   = 1'b1;
                    tmr_val    = T_W'(COOLDOWN_CYCLES - 1);
                end else begin
                    tmr_en = 1'b1;
                end
            end
            StCooldown: begin
                if (tmr_zero) begin
                    state_d = StIdle;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            conf_q     <= '0;
            drop_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            conf_q     <= conf_d;
            drop_cnt_q <= drop_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign drop_en   = (state_q == StArmed) || (state_q == StConfirm) || (state_q == StRelease);
    assign release_o = (state_q == StRelease);
    assign drop_cnt  = drop_cnt_q;
    assign timeout_o = timeout_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_baggage_drop_ctrl.sv
// Directed self-checking bench for baggage_drop_ctrl with default parameters.
module tb_baggage_drop_ctrl;

    logic        clk;
    logic        rst_n;
    logic        arm_req;
    logic        abort;
    logic [15:0] t_act;
    logic        t_act_valid;
    logic [15:0] t_lim;
    logic        drop_en;
    logic        release_o;
    logic [7:0]  drop_cnt;
    logic        timeout_o;
    logic [2:0]  state_o;

    int n_checks = 0;
    int n_errors = 0;

    baggage_drop_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arm_req     (arm_req),
        .abort       (abort),
        .t_act       (t_act),
        .t_act_valid (t_act_valid),
        .t_lim       (t_lim),
        .drop_en     (drop_en),
        .release_o   (release_o),
        .drop_cnt    (drop_cnt),
        .timeout_o   (timeout_o),
        .state_o     (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic valid, input logic [15:0] act, input logic [15:0] lim);
        t_act_valid = valid;
        t_act       = act;
        t_lim       = lim;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int max_cycles);
        for (int i = 0; i < max_cycles && state_o !== s; i++) tick();
        check(tag, state_o, s);
    endtask

    // Counts release_o high samples, including the current one.
    task automatic release_width(input string tag, input int exp);
        int w = 0;
        while (release_o === 1'b1 && w < 20) begin
            w++;
            tick();
        end
        check(tag, w, exp);
    endtask

    task automatic arm_and_confirm3();
        arm_req = 1'b1;
        tick();
        arm_req = 1'b0;
        sample(1'b1, 16'd100, 16'd120);
        tick();
        tick();
        tick();
        sample(1'b0, 16'd0, 16'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        arm_req = 1'b0;
        abort = 1'b0;
        sample(1'b0, 16'd0, 16'd0);
        #12;
        check("rst_state", state_o, 0);
        check("rst_drop_en", drop_en, 0);
        check("rst_release", release_o, 0);
        check("rst_cnt", drop_cnt, 0);
        check("rst_timeout", timeout_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Nominal drop
        arm_req = 1'b1;
        tick();
        check("nom_armed", state_o, 1);
        check("nom_drop_en", drop_en, 1);
        arm_req = 1'b0;
        sample(1'b1, 16'd100, 16'd120);
        tick();
        check("nom_conf1", state_o, 2);
        tick();
        check("nom_conf2", state_o, 2);
        tick();
        sample(1'b0, 16'd0, 16'd0);
        check("nom_release", state_o, 3);
        release_width("nom_rel_width", 4);
        check("nom_cooldown", state_o, 4);
        check("nom_cnt", drop_cnt, 1);
        check("nom_drop_en_cool", drop_en, 0);
        for (int i = 0; i < 7; i++) tick();
        check("nom_cool_last", state_o, 4);
        tick();
        check("nom_idle", state_o, 0);

        // Interrupted confirm; equal counts as ok
        arm_req = 1'b1;
        tick();
        arm_req = 1'b0;
        check("int_s1", state_o, 1);
        sample(1'b1, 16'd100, 16'd120);
        tick();
        check("int_s2", state_o, 2);
        tick();
        check("int_s3", state_o, 2);
        sample(1'b1, 16'd130, 16'd120);
        tick();
        check("int_bad", state_o, 1);
        sample(1'b1, 16'd120, 16'd120);
        tick();
        check("int_eq_ok", state_o, 2);
        tick();
        check("int_s6", state_o, 2);
        tick();
        check("int_rel", state_o, 3);
        sample(1'b0, 16'd0, 16'd0);
        release_width("int_rel_width", 4);
        check("int_cnt", drop_cnt, 2);
        wait_state("int_idle", 0, 20);

        // Abort beats the completing sample
        arm_req = 1'b1;
        tick();
        arm_req = 1'b0;
        sample(1'b1, 16'd50, 16'd60);
        tick();
        tick();
        check("ab_conf", state_o, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        sample(1'b0, 16'd0, 16'd0);
        check("ab_idle", state_o, 0);
        check("ab_norel", release_o, 0);
        check("ab_cnt", drop_cnt, 2);

        // Abort and arm_req ignored during RELEASE
        arm_and_confirm3();
        check("abr_rel", state_o, 3);
        abort = 1'b1;
        arm_req = 1'b1;
        release_width("abr_width", 4);
        abort = 1'b0;
        arm_req = 1'b0;
        check("abr_cnt", drop_cnt, 3);
        wait_state("abr_idle", 0, 20);

        // Timeout
        arm_req = 1'b1;
        tick();
        arm_req = 1'b0;
        for (int i = 0; i < 999; i++) tick();
        check("to_still_armed", state_o, 1);
        check("to_no_flag_yet", timeout_o, 0);
        tick();
        check("to_idle", state_o, 0);
        check("to_flag", timeout_o, 1);
        check("to_drop_en", drop_en, 0);
        tick();
        tick();
        check("to_sticky", timeout_o, 1);
        arm_req = 1'b1;
        tick();
        arm_req = 1'b0;
        check("to_rearm", state_o, 1);
        check("to_clear", timeout_o, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("to_abort", state_o, 0);

        // Async reset mid-RELEASE
        arm_and_confirm3();
        tick();
        check("ar_rel", release_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_release", release_o, 0);
        check("ar_drop_en", drop_en, 0);
        check("ar_state", state_o, 0);
        check("ar_cnt", drop_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Wrap with arm_req held high
        begin
            int drops = 0;
            int run = 0;
            int min_run = 1000;
            int max_run = 0;
            logic [2:0] prev;
            arm_req = 1'b1;
            sample(1'b1, 16'd100, 16'd120);
            prev = state_o;
            for (int i = 0; i < 5000 && drops < 256; i++) begin
                tick();
                if (state_o == 3'd4) begin
                    run++;
                    if (prev != 3'd4) drops++;
                end else if (prev == 3'd4) begin
                    if (run < min_run) min_run = run;
                    if (run > max_run) max_run = run;
                    run = 0;
                end
                prev = state_o;
            end
            check("wrap_drops", drops, 256);
            check("wrap_cnt", drop_cnt, 0);
            check("wrap_cool_min", min_run, 8);
            check("wrap_cool_max", max_run, 8);
            arm_req = 1'b0;
            sample(1'b0, 16'd0, 16'd0);
            wait_state("wrap_idle", 0, 20);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
